// File: rtl/pixel_stream_pkg.sv
// Shared constants and types for the pixel stream blocks.
package pixel_stream_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W     = 128;
    localparam int unsigned IMG_H     = 128;
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
    localparam int unsigned ADDR_W    = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } beat_t;

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Frame-memory read port plus outgoing valid/ready pixel stream.
interface pixel_stream_tx_if
    import pixel_stream_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_W,
    parameter int unsigned ADDR_W = 14
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              sof;
    logic              eol;
    logic              eof;

    modport master (
        output mem_rd_en, mem_addr, data_out, data_valid, sof, eol, eof,
        input  mem_rd_data, data_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, data_out, data_valid, sof, eol, eof,
        output mem_rd_data, data_ready
    );
endinterface

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO of pixel beats; head is presented from a register.
module pixel_skid_fifo
    import pixel_stream_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  beat_t push_data_i,
    input  logic  pop_i,
    output beat_t head_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int unsigned DEPTH = 2;

    beat_t      slot_q [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       full_q, empty_q;
    logic       do_push, do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle
    always_comb begin
        do_pop   = pop_i & ~empty_q;
        do_push  = push_i & (~full_q | do_pop);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    // Storage, pointers and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == 2'd2);
            empty_q  <= (cnt_d == 2'd0);
        end
    end

    assign head_o  = slot_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/pixel_stream_tx.sv
// Reads one frame from a synchronous memory and streams it in raster order
// with sof/eol/eof markers. A returning read bypasses the FIFO when it is
// empty, so the first pixel is offered in the same cycle its data arrives.
module pixel_stream_tx
    import pixel_stream_pkg::*;
#(
    parameter int unsigned IMG_W  = pixel_stream_pkg::IMG_W,
    parameter int unsigned IMG_H  = pixel_stream_pkg::IMG_H,
    parameter int unsigned DATA_W = pixel_stream_pkg::PIX_W,
    parameter int unsigned ADDR_W = pixel_stream_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    pixel_stream_tx_if.master bus
);
    localparam int unsigned FRAME_N = IMG_W * IMG_H;
    localparam int unsigned COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_N - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              infl_q, infl_d;
    logic [2:0]        infl_mark_q, infl_mark_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    beat_t      fifo_head, infl_beat_c, head_c;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic       valid_c, pop_c, issue_c;
    logic [1:0] occ_c, occ_left_c;

    // Stream head selection, occupancy and the read-issue decision
    always_comb begin
        infl_beat_c.data = PIX_W'(bus.mem_rd_data);
        infl_beat_c.sof  = infl_mark_q[2];
        infl_beat_c.eol  = infl_mark_q[1];
        infl_beat_c.eof  = infl_mark_q[0];

        valid_c = ~fifo_empty | infl_q;
        head_c  = '0;
        if (!fifo_empty) begin
            head_c = fifo_head;
        end else if (infl_q) begin
            head_c = infl_beat_c;
        end

        pop_c      = valid_c & bus.data_ready;
        fifo_pop   = pop_c & ~fifo_empty;
        fifo_push  = infl_q & ~(fifo_empty & bus.data_ready);
        occ_c      = (fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1)) + 2'(infl_q);
        occ_left_c = occ_c - 2'(pop_c);
        issue_c    = (state_q == ST_RUN) && (occ_left_c < 2'd2);
    end

    // Next-state logic: frame sequencing, address and raster counters
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        col_d       = col_q;
        row_d       = row_q;
        infl_d      = issue_c;
        infl_mark_d = infl_mark_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (issue_c) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    infl_mark_d = {(col_q == '0) && (row_q == '0),
                                   (col_q == LAST_COL),
                                   (col_q == LAST_COL) && (row_q == LAST_ROW)};
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (occ_left_c == 2'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            infl_q      <= 1'b0;
            infl_mark_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            infl_q      <= infl_d;
            infl_mark_q <= infl_mark_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    pixel_skid_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (infl_beat_c),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.mem_rd_en  = issue_c;
    assign bus.mem_addr   = addr_q;
    assign bus.data_out   = DATA_W'(head_c.data);
    assign bus.data_valid = valid_c;
    assign bus.sof        = head_c.sof;
    assign bus.eol        = head_c.eol;
    assign bus.eof        = head_c.eof;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: a 128x128 instance and a 4x2 instance, each
// fed by a behavioural frame memory with one cycle of read latency.
`timescale 1ns/1ps
module tb_pixel_stream_tx;

    localparam int N_A = 128 * 128;
    localparam int W_A = 128;
    localparam int N_B = 8;
    localparam int W_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;

    pixel_stream_tx_if #(.DATA_W(8), .ADDR_W(14)) bus_a ();
    pixel_stream_tx_if #(.DATA_W(8), .ADDR_W(14)) bus_b ();

    pixel_stream_tx #(.IMG_W(128), .IMG_H(128), .DATA_W(8), .ADDR_W(14)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a), .bus(bus_a)
    );

    pixel_stream_tx #(.IMG_W(4), .IMG_H(2), .DATA_W(8), .ADDR_W(14)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b), .bus(bus_b)
    );

    logic [7:0] mem_a [N_A];
    logic [7:0] mem_b [N_B];

    // Frame memories: data for a read appears in the following cycle
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) bus_a.mem_rd_data <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_rd_en) bus_b.mem_rd_data <= mem_b[bus_b.mem_addr[2:0]];
    end

    int checks   = 0;
    int failures = 0;

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({busy_a, done_a, bus_a.data_valid, bus_a.mem_rd_en, bus_a.sof, bus_a.eol, bus_a.eof} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl_a got=%b exp=0000000",
                     {busy_a, done_a, bus_a.data_valid, bus_a.mem_rd_en, bus_a.sof, bus_a.eol, bus_a.eof});
        end
        checks++;
        if (bus_a.data_out !== 8'd0 || bus_a.mem_addr !== 14'd0) begin
            failures++;
            $display("FAIL reset_bus_a got data=%h addr=%h exp data=00 addr=0000", bus_a.data_out, bus_a.mem_addr);
        end
        checks++;
        if ({busy_b, done_b, bus_b.data_valid, bus_b.mem_rd_en, bus_b.sof, bus_b.eol, bus_b.eof} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl_b got=%b exp=0000000",
                     {busy_b, done_b, bus_b.data_valid, bus_b.mem_rd_en, bus_b.sof, bus_b.eol, bus_b.eof});
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        int beat = 0;
        int dones = 0;
        int first_k = -1;
        int last_k = -1;
        int done_k = -1;
        logic [10:0] exp_v;
        for (int i = 0; i < N_A; i++) mem_a[i] = 8'(i);
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            bus_a.data_ready = 1'b1;
            start_a = 1'b0;
        end
        next_cycle();
        start_a = 1'b1;
        #1;
        for (int k = 1; k <= N_A + 6; k++) begin
            next_cycle();
            start_a = 1'b0;
            #1;
            if (k == 1) begin
                checks++;
                if (bus_a.mem_rd_en !== 1'b1 || bus_a.mem_addr !== 14'd0 || busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL first_read got rd_en=%b addr=%0d busy=%b exp 1/0/1",
                             bus_a.mem_rd_en, bus_a.mem_addr, busy_a);
                end
            end
            if (bus_a.data_valid === 1'b1) begin
                if (beat == 0) first_k = k;
                last_k = k;
                if (beat < N_A) begin
                    exp_v = {mem_a[beat], beat == 0, (beat % W_A) == W_A - 1, beat == N_A - 1};
                    checks++;
                    if ({bus_a.data_out, bus_a.sof, bus_a.eol, bus_a.eof} !== exp_v) begin
                        failures++;
                        $display("FAIL full_beat%0d got=%h exp=%h", beat,
                                 {bus_a.data_out, bus_a.sof, bus_a.eol, bus_a.eof}, exp_v);
                    end
                end
                beat++;
            end
            if (done_a === 1'b1) begin
                dones++;
                done_k = k;
            end
        end
        checks++;
        if (first_k != 2) begin
            failures++;
            $display("FAIL full_first_beat_cycle got=%0d exp=2", first_k);
        end
        checks++;
        if (last_k != N_A + 1 || beat != N_A) begin
            failures++;
            $display("FAIL full_last_beat got cycle=%0d beats=%0d exp cycle=%0d beats=%0d", last_k, beat, N_A + 1, N_A);
        end
        checks++;
        if (done_k != N_A + 2 || dones != 1) begin
            failures++;
            $display("FAIL full_done got cycle=%0d count=%0d exp cycle=%0d count=1", done_k, dones, N_A + 2);
        end
    endtask

    task automatic test_small_frame();
        int beat = 0;
        int dones = 0;
        logic [10:0] exp_v;
        for (int i = 0; i < N_B; i++) mem_b[i] = 8'h10 + 8'(i);
        next_cycle();
        bus_b.data_ready = 1'b1;
        start_b = 1'b1;
        #1;
        for (int k = 1; k <= 14; k++) begin
            next_cycle();
            start_b = 1'b0;
            #1;
            if (bus_b.data_valid === 1'b1) begin
                if (beat < N_B) begin
                    exp_v = {mem_b[beat], beat == 0, (beat % W_B) == W_B - 1, beat == N_B - 1};
                    checks++;
                    if ({bus_b.data_out, bus_b.sof, bus_b.eol, bus_b.eof} !== exp_v || k != beat + 2) begin
                        failures++;
                        $display("FAIL small_beat%0d got=%h at cycle %0d exp=%h at cycle %0d", beat,
                                 {bus_b.data_out, bus_b.sof, bus_b.eol, bus_b.eof}, k, exp_v, beat + 2);
                    end
                end
                beat++;
            end
            if (done_b === 1'b1) dones++;
        end
        checks++;
        if (beat != N_B || dones != 1) begin
            failures++;
            $display("FAIL small_count got beats=%0d dones=%0d exp beats=8 dones=1", beat, dones);
        end
    endtask

    task automatic test_random_ready();
        int beat = 0;
        int issued = 0;
        int dones = 0;
        int k = 0;
        logic prev_stall = 1'b0;
        logic [10:0] prev_v = '0;
        logic [10:0] cur_v;
        logic [10:0] exp_v;
        for (int i = 0; i < N_A; i++) mem_a[i] = 8'($urandom);
        next_cycle();
        bus_a.data_ready = 1'b0;
        start_a = 1'b1;
        #1;
        while (dones == 0 && k < 3 * N_A) begin
            next_cycle();
            start_a = 1'b0;
            bus_a.data_ready = 1'($urandom_range(0, 1));
            #1;
            k++;
            cur_v = {bus_a.data_out, bus_a.sof, bus_a.eol, bus_a.eof};
            if (prev_stall) begin
                checks++;
                if (bus_a.data_valid !== 1'b1 || cur_v !== prev_v) begin
                    failures++;
                    $display("FAIL stall_hold cycle %0d got valid=%b beat=%h exp valid=1 beat=%h",
                             k, bus_a.data_valid, cur_v, prev_v);
                end
            end
            if (bus_a.mem_rd_en === 1'b1) issued++;
            if (bus_a.data_valid === 1'b1 && bus_a.data_ready) begin
                if (beat < N_A) begin
                    exp_v = {mem_a[beat], beat == 0, (beat % W_A) == W_A - 1, beat == N_A - 1};
                    checks++;
                    if (cur_v !== exp_v) begin
                        failures++;
                        $display("FAIL rand_beat%0d got=%h exp=%h", beat, cur_v, exp_v);
                    end
                end
                beat++;
            end
            checks++;
            if (issued - beat > 2) begin
                failures++;
                $display("FAIL occupancy cycle %0d got=%0d exp<=2", k, issued - beat);
            end
            prev_stall = bus_a.data_valid & ~bus_a.data_ready;
            prev_v = cur_v;
            if (done_a === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || beat != N_A || issued != N_A) begin
            failures++;
            $display("FAIL rand_totals got dones=%0d beats=%0d reads=%0d exp 1/%0d/%0d", dones, beat, issued, N_A, N_A);
        end
    endtask

    task automatic test_stall_start();
        int reads = 0;
        logic [13:0] addrs [$];
        for (int i = 0; i < N_A; i++) mem_a[i] = 8'(i * 3 + 1);
        next_cycle();
        bus_a.data_ready = 1'b0;
        start_a = 1'b1;
        #1;
        for (int k = 1; k <= 20; k++) begin
            next_cycle();
            start_a = 1'b0;
            #1;
            if (bus_a.mem_rd_en === 1'b1) begin
                reads++;
                addrs.push_back(bus_a.mem_addr);
            end
        end
        checks++;
        if (reads != 2 || addrs.size() != 2 || addrs[0] !== 14'd0 || addrs[1] !== 14'd1) begin
            failures++;
            $display("FAIL stall_reads got count=%0d exp count=2 at addr 0,1", reads);
        end
        checks++;
        if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== mem_a[0] || bus_a.sof !== 1'b1) begin
            failures++;
            $display("FAIL stall_head got valid=%b data=%h sof=%b exp 1/%h/1",
                     bus_a.data_valid, bus_a.data_out, bus_a.sof, mem_a[0]);
        end
        for (int j = 0; j < 16; j++) begin
            next_cycle();
            bus_a.data_ready = 1'b1;
            #1;
            checks++;
            if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== mem_a[j] || bus_a.sof !== (j == 0)) begin
                failures++;
                $display("FAIL resume_beat%0d got valid=%b data=%h sof=%b exp 1/%h/%b",
                         j, bus_a.data_valid, bus_a.data_out, bus_a.sof, mem_a[j], j == 0);
            end
        end
        next_cycle();
        bus_a.data_ready = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_second_start();
        int beat = 0;
        int dones = 0;
        logic [7:0] exp_d;
        for (int i = 0; i < N_A; i++) mem_a[i] = 8'(i ^ 8'h5A);
        next_cycle();
        bus_a.data_ready = 1'b1;
        start_a = 1'b1;
        #1;
        for (int k = 1; k <= N_A + 10; k++) begin
            next_cycle();
            start_a = 1'b0;
            #1;
            if (bus_a.data_valid === 1'b1) begin
                if (beat == 50) start_a = 1'b1;
                if (beat < N_A) begin
                    exp_d = mem_a[beat];
                    checks++;
                    if (bus_a.data_out !== exp_d) begin
                        failures++;
                        $display("FAIL restart_beat%0d got=%h exp=%h", beat, bus_a.data_out, exp_d);
                    end
                end
                beat++;
            end
            if (done_a === 1'b1) dones++;
        end
        checks++;
        if (beat != N_A || dones != 1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL second_start got beats=%0d dones=%0d busy=%b exp %0d/1/0", beat, dones, busy_a, N_A);
        end
    endtask

    task automatic test_reset_mid();
        int beat = 0;
        logic hit = 1'b0;
        for (int i = 0; i < N_A; i++) mem_a[i] = 8'(8'hC3 - i);
        next_cycle();
        bus_a.data_ready = 1'b1;
        start_a = 1'b1;
        #1;
        for (int k = 1; k <= 200 && !hit; k++) begin
            next_cycle();
            start_a = 1'b0;
            #1;
            if (bus_a.data_valid === 1'b1) begin
                if (beat == 100) begin
                    rst = 1'b1;
                    hit = 1'b1;
                end
                beat++;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reset_mid_timeout got beats=%0d exp>=101", beat);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_a, bus_a.data_valid, bus_a.mem_rd_en, done_a} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_quiet got busy/valid/rd_en/done=%b exp=0000",
                     {busy_a, bus_a.data_valid, bus_a.mem_rd_en, done_a});
        end
        next_cycle();
        start_a = 1'b1;
        #1;
        next_cycle();
        start_a = 1'b0;
        #1;
        checks++;
        if (bus_a.mem_rd_en !== 1'b1 || bus_a.mem_addr !== 14'd0) begin
            failures++;
            $display("FAIL restart_read got rd_en=%b addr=%0d exp 1/0", bus_a.mem_rd_en, bus_a.mem_addr);
        end
        next_cycle();
        #1;
        checks++;
        if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== mem_a[0] || bus_a.sof !== 1'b1) begin
            failures++;
            $display("FAIL restart_first got valid=%b data=%h sof=%b exp 1/%h/1",
                     bus_a.data_valid, bus_a.data_out, bus_a.sof, mem_a[0]);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bus_a.data_ready = 1'b0;
        bus_b.data_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_small_frame();
        test_random_ready();
        test_stall_start();
        test_second_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(3_000_000);
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
